// File: rtl/game_pkg.sv
// Shared game constants and the player-bullet state encoding.
// Also provides the counter-width helper used by the bullet controller.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_COOL = 2'd2
  } bullet_state_e;

  // Bits needed to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/player_bullet_ctrl.sv
// Player bullet controller: spawns one bullet on fire, moves it up each frame,
// ends it on hit or top-of-screen exit, then enforces a frame-based cooldown.
module player_bullet_ctrl
  import game_pkg::*;
#(
  parameter int SPEED    = 8,
  parameter int COOLDOWN = 12,
  parameter int X_OFS    = 20,
  parameter int BULLET_H = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] p_x,
  input  logic [9:0] p_y,
  input  logic       hit,
  output logic [9:0] b_x,
  output logic [9:0] b_y,
  output logic       mybullet_en,
  output logic [7:0] shots
);

  localparam int              CW       = cnt_width(COOLDOWN);
  localparam logic [9:0]      SPEED_V  = 10'(SPEED);
  localparam logic [9:0]      X_OFS_V  = 10'(X_OFS);
  localparam logic [9:0]      BH_V     = 10'(BULLET_H);
  localparam logic [CW-1:0]   COOL_V   = CW'(COOLDOWN);

  bullet_state_e state, state_n;
  logic [9:0]    bx_n, by_n;
  logic [7:0]    shots_n;
  logic [CW-1:0] cnt, cnt_n;

  // NOTE: every always_comb output is given a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    bx_n    = b_x;
    by_n    = b_y;
    cnt_n   = cnt;
    shots_n = shots;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          state_n = ST_FLY;
          bx_n    = p_x + X_OFS_V;
          by_n    = (p_y < BH_V) ? 10'd0 : p_y - BH_V;
          shots_n = shots + 8'd1;
        end
      end
      ST_FLY: begin
        // A hit freezes the bullet where it is, even on a movement frame.
        if (hit) begin
          state_n = ST_COOL;
          cnt_n   = COOL_V;
        end else if (frame_tick) begin
          if (b_y >= SPEED_V) begin
            by_n = b_y - SPEED_V;
          end else begin
            by_n    = 10'd0;
            state_n = ST_COOL;
            cnt_n   = COOL_V;
          end
        end
      end
      ST_COOL: begin
        if (COOLDOWN == 0) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (frame_tick) begin
          if (cnt <= CW'(1)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      b_x         <= '0;
      b_y         <= '0;
      cnt         <= '0;
      shots       <= '0;
      mybullet_en <= 1'b0;
    end else begin
      state       <= state_n;
      b_x         <= bx_n;
      b_y         <= by_n;
      cnt         <= cnt_n;
      shots       <= shots_n;
      mybullet_en <= (state_n == ST_FLY);
    end
  end

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Bench for player_bullet_ctrl: directed scenarios plus random traffic, all
// compared against a frame-level bullet model for default and zero cooldown.
module tb_player_bullet_ctrl;

  localparam int SPEED    = 8;
  localparam int COOLDOWN = 12;
  localparam int X_OFS    = 20;
  localparam int BULLET_H = 40;

  logic       clk = 1'b0;
  logic       rst, frame_tick, fire, hit;
  logic [9:0] p_x, p_y;
  logic [9:0] b_x, b_y, z_b_x, z_b_y;
  logic       mybullet_en, z_en;
  logic [7:0] shots, z_shots;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit flying;
    bit resting;
    int rest_left;
    int x;
    int y;
    int shots;
  } model_t;

  model_t ma, mz;

  player_bullet_ctrl #(.SPEED(SPEED), .COOLDOWN(COOLDOWN), .X_OFS(X_OFS),
                       .BULLET_H(BULLET_H)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
    .p_x(p_x), .p_y(p_y), .hit(hit), .b_x(b_x), .b_y(b_y),
    .mybullet_en(mybullet_en), .shots(shots)
  );

  player_bullet_ctrl #(.SPEED(SPEED), .COOLDOWN(0), .X_OFS(X_OFS),
                       .BULLET_H(BULLET_H)) dut_z (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
    .p_x(p_x), .p_y(p_y), .hit(hit), .b_x(z_b_x), .b_y(z_b_y),
    .mybullet_en(z_en), .shots(z_shots)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the bullet's life, stated in terms of frames and pixels.
  function automatic model_t model_next(input model_t m, input int cd);
    model_t n = m;
    if (rst) begin
      n = '{default: 0};
    end else if (m.flying) begin
      if (hit) begin
        n.flying = 0; n.resting = 1; n.rest_left = cd;
      end else if (frame_tick) begin
        if (m.y >= SPEED) n.y = m.y - SPEED;
        else begin
          n.y = 0; n.flying = 0; n.resting = 1; n.rest_left = cd;
        end
      end
    end else if (m.resting) begin
      if (cd == 0) n.resting = 0;
      else if (frame_tick) begin
        if (m.rest_left <= 1) begin n.resting = 0; n.rest_left = 0; end
        else n.rest_left = m.rest_left - 1;
      end
    end else if (fire) begin
      n.flying = 1;
      n.x      = (int'(p_x) + X_OFS) % 1024;
      n.y      = (int'(p_y) < BULLET_H) ? 0 : int'(p_y) - BULLET_H;
      n.shots  = (m.shots + 1) % 256;
    end
    return n;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".bx"},    b_x,         ma.x);
    check({tag, ".by"},    b_y,         ma.y);
    check({tag, ".en"},    mybullet_en, ma.flying);
    check({tag, ".shots"}, shots,       ma.shots);
    check({tag, ".z_bx"},  z_b_x,       mz.x);
    check({tag, ".z_by"},  z_b_y,       mz.y);
    check({tag, ".z_en"},  z_en,        mz.flying);
    check({tag, ".z_sh"},  z_shots,     mz.shots);
  endtask

  task automatic step(input string tag);
    ma = model_next(ma, COOLDOWN);
    mz = model_next(mz, 0);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic tick_pulse(input string tag);
    frame_tick = 1'b1; step(tag);
    frame_tick = 1'b0; step(tag);
  endtask

  task automatic cool_down(input string tag);
    repeat (COOLDOWN) tick_pulse(tag);
    step(tag);
  endtask

  initial begin
    ma = '{default: 0};
    mz = '{default: 0};
    rst = 1'b1; frame_tick = 1'b0; fire = 1'b0; hit = 1'b0;
    p_x = '0; p_y = '0;
    step("rst");
    step("rst");
    rst = 1'b0;
    check("rst_bx", b_x, 0);
    check("rst_by", b_y, 0);
    check("rst_en", mybullet_en, 0);
    check("rst_shots", shots, 0);

    // Spawn from (300,400).
    p_x = 10'd300; p_y = 10'd400; fire = 1'b1;
    step("spawn");
    fire = 1'b0;
    check("spawn_bx", b_x, 320);
    check("spawn_by", b_y, 360);
    check("spawn_en", mybullet_en, 1);
    check("spawn_shots", shots, 1);

    repeat (3) tick_pulse("move");
    check("move_by", b_y, 336);
    hit = 1'b1; step("hit"); hit = 1'b0;
    check("hit_en", mybullet_en, 0);
    check("hit_by", b_y, 336);
    cool_down("cool1");

    // Exit through the top, then hold fire through the whole cooldown.
    p_y = 10'd45; fire = 1'b1; step("near_top"); fire = 1'b0;
    check("near_top_by", b_y, 5);
    frame_tick = 1'b1; step("exit"); frame_tick = 1'b0;
    check("exit_en", mybullet_en, 0);
    check("exit_by", b_y, 0);
    fire = 1'b1;
    for (int k = 1; k <= COOLDOWN; k++) begin
      tick_pulse("held_fire");
      check("respawn_timing", mybullet_en, (k == COOLDOWN) ? 1 : 0);
    end
    fire = 1'b0;
    hit = 1'b1; step("kill"); hit = 1'b0;
    cool_down("cool2");

    // Hit and frame tick together: no movement.
    p_y = 10'd140; fire = 1'b1; step("spawn100"); fire = 1'b0;
    check("spawn100_by", b_y, 100);
    hit = 1'b1; frame_tick = 1'b1; step("hit_tick");
    hit = 1'b0; frame_tick = 1'b0;
    check("hit_tick_by", b_y, 100);
    check("hit_tick_en", mybullet_en, 0);
    cool_down("cool3");

    // Spawn clamped at the top edge, then leave without wrapping.
    p_y = 10'd10; fire = 1'b1; step("clamp"); fire = 1'b0;
    check("clamp_by", b_y, 0);
    check("clamp_en", mybullet_en, 1);
    frame_tick = 1'b1; step("clamp_exit"); frame_tick = 1'b0;
    check("clamp_exit_by", b_y, 0);
    check("clamp_exit_en", mybullet_en, 0);
    cool_down("cool4");

    // Reset wins over a same-cycle hit while flying.
    p_x = 10'd5; p_y = 10'd200; fire = 1'b1; step("pre_rst"); fire = 1'b0;
    rst = 1'b1; hit = 1'b1; step("rst_fly"); rst = 1'b0; hit = 1'b0;
    check("rst_fly_bx", b_x, 0);
    check("rst_fly_by", b_y, 0);
    check("rst_fly_en", mybullet_en, 0);
    check("rst_fly_shots", shots, 0);

    // Shot counter wrap; x offset wraps at 1024.
    p_x = 10'd1010; p_y = 10'd300;
    for (int s = 1; s <= 256; s++) begin
      fire = 1'b1; step("wrap_fire"); fire = 1'b0;
      if (s == 1) check("wrap_bx", b_x, 6);
      if (s == 255) check("shots255", shots, 255);
      hit = 1'b1; step("wrap_hit"); hit = 1'b0;
      repeat (COOLDOWN) tick_pulse("wrap_cool");
    end
    step("wrap_end");
    check("shots_wrap", shots, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(63) == 0);
      fire       = ($urandom_range(2) == 0);
      hit        = ($urandom_range(7) == 0);
      frame_tick = ($urandom_range(3) == 0);
      p_x        = 10'($urandom_range(1023));
      p_y        = 10'($urandom_range(1023));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_bullet_ctrl.md
PLAYER_BULLET_CTRL -- requirements
Module: player_bullet_ctrl

Interface
REQ-001 Parameter SPEED, default 8: pixels the bullet moves up per frame_tick.
REQ-002 Parameter COOLDOWN, default 12: frame_ticks after a bullet ends before a new shot is accepted.
REQ-003 Parameter X_OFS, default 20: horizontal offset from player origin to bullet spawn x.
REQ-004 Parameter BULLET_H, default 40: bullet height; spawn y is this far above the player origin.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 fire  input  1  level request to shoot, sampled every cycle.
REQ-009 p_x, p_y  input  10 each  current player origin.
REQ-010 hit  input  1  one-cycle pulse from the enemy hit judge: the bullet struck an enemy.
REQ-011 b_x, b_y  output  10 each  current bullet position.
REQ-012 mybullet_en  output  1  bullet is live and may be judged.
REQ-013 shots  output  8  count of bullets spawned since reset.

Function
REQ-014 The FSM SHALL have states IDLE, FLY and COOL, encoded in 2 bits.
REQ-015 IDLE with fire=1: next cycle FLY, b_x=p_x+X_OFS mod 1024, b_y=p_y-BULLET_H (0 if p_y<BULLET_H), mybullet_en=1, shots+1 (wraps 255->0).
REQ-016 IDLE with fire=0: all outputs hold; frame_tick ignored.
REQ-017 FLY with hit=1: next cycle COOL, mybullet_en=0, b_x/b_y hold; cooldown counter loads COOLDOWN.
REQ-018 FLY, hit=0, frame_tick=1, b_y>=SPEED: b_y decreases by SPEED; b_x holds.
REQ-019 FLY, hit=0, frame_tick=1, b_y<SPEED: bullet leaves the screen; next cycle COOL, mybullet_en=0, b_y=0; no underflow wrap.
REQ-020 hit and frame_tick in the same FLY cycle: hit wins; no movement.
REQ-021 hit outside FLY SHALL be ignored.
REQ-022 fire during FLY or COOL SHALL be ignored; no queued shot.
REQ-023 COOL: each frame_tick decrements the counter; a tick with counter<=1 moves to IDLE the next cycle.
REQ-024 COOLDOWN=0: COOL exits to IDLE on the next cycle, independent of frame_tick.
REQ-025 mybullet_en SHALL be 1 exactly when state is FLY; all outputs registered; latency fire->mybullet_en is 1 cycle.
REQ-026 Cooldown counter width SHALL be $clog2(COOLDOWN+1), minimum 1 bit.

Reset
REQ-027 rst=1 SHALL give state IDLE, b_x=0, b_y=0, mybullet_en=0, shots=0, cooldown counter 0 on the following edge, from any state.
REQ-028 rst SHALL take priority over fire, hit and frame_tick in the same cycle.

Structure
REQ-029 Screen constants SCREEN_W=640, SCREEN_H=480 and the state encoding SHALL be in shared package game_pkg.
REQ-030 The design is a single module with no sub-modules; the cooldown counter is inline.

Verification
REQ-031 Reset, p_x=300, p_y=400, fire=1 for one cycle -> next cycle b_x=320, b_y=360, mybullet_en=1, shots=1.
REQ-032 FLY at b_y=360, three frame_ticks -> b_y=336; hit pulse -> next cycle mybullet_en=0, state COOL, b_y holds 336.
REQ-033 FLY at b_y=5, frame_tick -> mybullet_en=0, b_y=0; fire held high through 12 frame_ticks -> respawn only after the 12th tick, not earlier.
REQ-034 Same-cycle hit and frame_tick at b_y=100 -> b_y stays 100, mybullet_en=0.
REQ-035 p_y=10 at fire -> b_y=0; frame_tick -> bullet ends without wrap, b_y=0.
REQ-036 rst asserted in FLY together with hit -> next cycle all outputs 0, state IDLE; 256 shots -> shots wraps to 0.
